// File: rtl/evm_pkg.sv
// Shared constants for the ballot front end: party codes, button bit positions
// and the ballot FSM state type.
package evm_pkg;

   localparam logic [3:0] PARTY_NONE = 4'b0000;
   localparam logic [3:0] PARTY_BJP  = 4'b0001;
   localparam logic [3:0] PARTY_INC  = 4'b0010;
   localparam logic [3:0] PARTY_RJD  = 4'b0011;
   localparam logic [3:0] PARTY_JDU  = 4'b0100;
   localparam logic [3:0] PARTY_BSP  = 4'b0101;
   localparam logic [3:0] PARTY_SP   = 4'b0110;
   localparam logic [3:0] PARTY_NCP  = 4'b0111;
   localparam logic [3:0] PARTY_INP  = 4'b1000;
   localparam logic [3:0] PARTY_NOTA = 4'b1001;

   localparam int unsigned BTN_BJP  = 0;
   localparam int unsigned BTN_INC  = 1;
   localparam int unsigned BTN_RJD  = 2;
   localparam int unsigned BTN_JDU  = 3;
   localparam int unsigned BTN_BSP  = 4;
   localparam int unsigned BTN_SP   = 5;
   localparam int unsigned BTN_NCP  = 6;
   localparam int unsigned BTN_INP  = 7;
   localparam int unsigned BTN_NOTA = 8;
   localparam int unsigned NUM_BTN  = 9;

   typedef enum logic [2:0] {LOCKED, ARMED, SETUP, STROBE, WAIT_REL} ballot_state_t;

   // Only meaningful for a one-hot pattern; the FSM guarantees that at latch time.
   function automatic logic [3:0] party_code(input logic [NUM_BTN-1:0] btn);
      logic [3:0] code;
      code = PARTY_NONE;
      case (1'b1)
         btn[BTN_BJP]:  code = PARTY_BJP;
         btn[BTN_INC]:  code = PARTY_INC;
         btn[BTN_RJD]:  code = PARTY_RJD;
         btn[BTN_JDU]:  code = PARTY_JDU;
         btn[BTN_BSP]:  code = PARTY_BSP;
         btn[BTN_SP]:   code = PARTY_SP;
         btn[BTN_NCP]:  code = PARTY_NCP;
         btn[BTN_INP]:  code = PARTY_INP;
         btn[BTN_NOTA]: code = PARTY_NOTA;
         default:       code = PARTY_NONE;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] btn_popcount(input logic [NUM_BTN-1:0] btn);
      logic [3:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         cnt = cnt + 4'(btn[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/evm_debounce.sv
// Multi-stage synchroniser plus a saturating stability counter over a vector.
// The counter restarts on any pattern change or when the owner asserts clear_i.
module evm_debounce #(
   parameter int unsigned WIDTH         = 9,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] sync_o,
   output logic             stable_o
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             changed;

   assign sync_o  = sync_q[SYNC_STAGES-1];
   assign changed = (sync_o != prev_q);
   // A change in the current cycle vetoes acceptance even if the count is full.
   assign stable_o = (cnt_q == CW'(STABLE_CYCLES)) && !changed;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || changed) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q[0] <= din_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_o;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/evm_ballot_unit.sv
// Voter-side ballot front end: one debounced one-hot press per ballot release,
// converted to a party code and an en strobe for the downstream vote counter.
module evm_ballot_unit
   import evm_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned STROBE_CYCLES   = 2,
   parameter int unsigned TOTAL_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ballot_release,
   input  logic [NUM_BTN-1:0] party_btn,
   output logic [3:0]         button_code,
   output logic               vote_en,
   output logic               ready_led,
   output logic               busy_led,
   output logic               multi_err,
   output logic [TOTAL_W-1:0] total_cast
);

   localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);

   ballot_state_t      state_q, state_d;
   logic [NUM_BTN-1:0] btn_sync;
   logic               btn_stable, db_clear, one_hot;
   logic [3:0]         pop;
   logic               rel_sync_q [SYNC_STAGES];
   logic               rel_prev_q, rel_rise;
   logic [3:0]         code_q, code_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic [SW-1:0]      str_cnt_q, str_cnt_d;
   logic               multi_q, multi_d;

   evm_debounce #(
      .WIDTH         (NUM_BTN),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk      (clk),
      .rst      (rst),
      .din_i    (party_btn),
      .clear_i  (db_clear),
      .sync_o   (btn_sync),
      .stable_o (btn_stable)
   );

   assign pop      = btn_popcount(btn_sync);
   assign one_hot  = (pop == 4'd1);
   assign rel_rise = rel_sync_q[SYNC_STAGES-1] && !rel_prev_q;

   // The shared counter tracks one-hot stability in ARMED and all-zero in WAIT_REL.
   always_comb begin
      case (state_q)
         ARMED:    db_clear = !one_hot;
         WAIT_REL: db_clear = (btn_sync != '0);
         default:  db_clear = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LOCKED;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOCKED:   if (rel_rise) state_d = ARMED;
         ARMED:    if (btn_stable && one_hot) state_d = SETUP;
         SETUP:    state_d = STROBE;
         STROBE:   if (str_cnt_q == SW'(STROBE_CYCLES - 1)) state_d = WAIT_REL;
         WAIT_REL: if (btn_stable && (btn_sync == '0)) state_d = LOCKED;
         default:  state_d = LOCKED;
      endcase
   end

   always_comb begin
      ready_led = (state_q == ARMED);
      busy_led  = (state_q == SETUP) || (state_q == STROBE) || (state_q == WAIT_REL);
      vote_en   = (state_q == STROBE);
   end

   always_comb begin
      code_d = code_q;
      if (state_q == ARMED && state_d == SETUP)     code_d = party_code(btn_sync);
      if (state_q == WAIT_REL && state_d == LOCKED) code_d = PARTY_NONE;
      total_d   = total_q + TOTAL_W'(state_q == STROBE && state_d == WAIT_REL);
      str_cnt_d = (state_q == STROBE) ? str_cnt_q + 1'b1 : '0;
      multi_d   = (state_q == ARMED) && (pop > 4'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) rel_sync_q[i] <= 1'b0;
         rel_prev_q <= 1'b0;
         code_q     <= '0;
         total_q    <= '0;
         str_cnt_q  <= '0;
         multi_q    <= 1'b0;
      end else begin
         rel_sync_q[0] <= ballot_release;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) rel_sync_q[i] <= rel_sync_q[i-1];
         rel_prev_q <= rel_sync_q[SYNC_STAGES-1];
         code_q     <= code_d;
         total_q    <= total_d;
         str_cnt_q  <= str_cnt_d;
         multi_q    <= multi_d;
      end
   end

   assign button_code = code_q;
   assign total_cast  = total_q;
   assign multi_err   = multi_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit (SYNC=2, DEBOUNCE=4, STROBE=2).
// A press driven just after clock edge 0 shows vote_en high after edge 9.
module tb_evm_ballot_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ballot_release;
   logic [8:0]  party_btn;
   logic [3:0]  button_code;
   logic        vote_en, ready_led, busy_led, multi_err;
   logic [15:0] total_cast;

   int n_cmp = 0;
   int n_bad = 0;
   int votes = 0;
   int cnt [16] = '{default: 0};

   always #5 clk = ~clk;

   evm_ballot_unit #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .STROBE_CYCLES   (2),
      .TOTAL_W         (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ballot_release (ballot_release),
      .party_btn      (party_btn),
      .button_code    (button_code),
      .vote_en        (vote_en),
      .ready_led      (ready_led),
      .busy_led       (busy_led),
      .multi_err      (multi_err),
      .total_cast     (total_cast)
   );

   // Downstream counter model: codes 1..8 are parties, anything else lands in nota (9).
   always @(posedge vote_en) begin
      votes++;
      if (button_code >= 4'd1 && button_code <= 4'd8) cnt[button_code]++;
      else cnt[9]++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic arm(input string tag);
      ballot_release = 1'b1;
      repeat (3) tick();
      chk({tag, "_armed"}, 32'(ready_led), 32'd1);
      ballot_release = 1'b0;
   endtask

   task automatic wait_vote(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!vote_en && n < 30);
      chk({tag, "_vote_seen"}, 32'(vote_en), 32'd1);
   endtask

   task automatic settle(input string tag);
      int n;
      party_btn = '0;
      n = 0;
      while (busy_led && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_locked"}, 32'(busy_led), 32'd0);
      chk({tag, "_code_clr"}, 32'(button_code), 32'd0);
   endtask

   initial begin
      int n, v0, c0;
      rst = 1'b1;
      ballot_release = 1'b0;
      party_btn = '0;
      tick();
      tick();
      chk("rst_code", 32'(button_code), 32'd0);
      chk("rst_vote", 32'(vote_en), 32'd0);
      chk("rst_ready", 32'(ready_led), 32'd0);
      chk("rst_busy", 32'(busy_led), 32'd0);
      chk("rst_multi", 32'(multi_err), 32'd0);
      chk("rst_total", 32'(total_cast), 32'd0);
      rst = 1'b0;
      tick();

      // Clean rjd press, cycle-exact
      arm("s1");
      party_btn = 9'b000000100;
      repeat (7) tick();
      chk("s1_ready_t7", 32'(ready_led), 32'd1);
      tick();
      chk("s1_code_t8", 32'(button_code), 32'h3);
      chk("s1_vote_t8", 32'(vote_en), 32'd0);
      chk("s1_ready_t8", 32'(ready_led), 32'd0);
      chk("s1_busy_t8", 32'(busy_led), 32'd1);
      tick();
      chk("s1_vote_t9", 32'(vote_en), 32'd1);
      tick();
      chk("s1_vote_t10", 32'(vote_en), 32'd1);
      chk("s1_code_t10", 32'(button_code), 32'h3);
      party_btn = '0;
      tick();
      chk("s1_vote_t11", 32'(vote_en), 32'd0);
      chk("s1_total", 32'(total_cast), 32'd1);
      repeat (6) tick();
      chk("s1_busy_t17", 32'(busy_led), 32'd1);
      tick();
      chk("s1_busy_t18", 32'(busy_led), 32'd0);
      chk("s1_code_t18", 32'(button_code), 32'd0);
      chk("s1_cnt_rjd", 32'(cnt[3]), 32'd1);

      // Press without a ballot release
      v0 = votes;
      party_btn = 9'b000000001;
      repeat (12) tick();
      chk("s2_no_vote", 32'(votes), 32'(v0));
      chk("s2_ready", 32'(ready_led), 32'd0);
      chk("s2_total", 32'(total_cast), 32'd1);
      party_btn = '0;
      repeat (6) tick();

      // Two buttons held, then drop to bjp
      arm("s3");
      party_btn = 9'b000000011;
      repeat (10) tick();
      chk("s3_multi", 32'(multi_err), 32'd1);
      chk("s3_no_vote", 32'(votes), 32'(v0));
      party_btn = 9'b000000001;
      wait_vote("s3", n);
      chk("s3_latency", 32'(n), 32'd9);
      chk("s3_code", 32'(button_code), 32'h1);
      chk("s3_multi_clr", 32'(multi_err), 32'd0);
      settle("s3");
      chk("s3_total", 32'(total_cast), 32'd2);

      // Bouncing bjp, then stable
      arm("s4");
      v0 = votes;
      for (int i = 0; i < 6; i++) begin
         party_btn[0] = ~party_btn[0];
         tick();
         tick();
      end
      chk("s4_no_vote_bounce", 32'(votes), 32'(v0));
      party_btn = 9'b000000001;
      wait_vote("s4", n);
      chk("s4_latency", 32'(n), 32'd9);
      settle("s4");
      chk("s4_one_vote", 32'(votes), 32'(v0 + 1));
      chk("s4_total", 32'(total_cast), 32'd3);
      chk("s4_cnt_bjp", 32'(cnt[1]), 32'd2);

      // nota, with a release edge arriving while busy
      arm("s5");
      c0 = cnt[9];
      party_btn = 9'b100000000;
      wait_vote("s5", n);
      chk("s5_code", 32'(button_code), 32'h9);
      ballot_release = 1'b1;
      repeat (3) tick();
      ballot_release = 1'b0;
      settle("s5");
      repeat (4) tick();
      chk("s5_rel_ignored", 32'(ready_led), 32'd0);
      chk("s5_cnt_nota", 32'(cnt[9]), 32'(c0 + 1));
      chk("s5_total", 32'(total_cast), 32'd4);

      // Reset during the second strobe cycle
      arm("s6");
      party_btn = 9'b000000001;
      wait_vote("s6", n);
      tick();
      chk("s6_strobe2", 32'(vote_en), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("s6_rst_vote", 32'(vote_en), 32'd0);
      chk("s6_rst_code", 32'(button_code), 32'd0);
      chk("s6_rst_total", 32'(total_cast), 32'd0);
      chk("s6_rst_busy", 32'(busy_led), 32'd0);
      chk("s6_rst_ready", 32'(ready_led), 32'd0);
      chk("s6_cnt_bjp", 32'(cnt[1]), 32'd3);
      party_btn = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      arm("s6b");
      party_btn = 9'b000000010;
      wait_vote("s6b", n);
      chk("s6b_latency", 32'(n), 32'd9);
      chk("s6b_code", 32'(button_code), 32'h2);
      settle("s6b");
      chk("s6b_total", 32'(total_cast), 32'd1);
      chk("s6b_cnt_inc", 32'(cnt[2]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
